// File: rtl/mfcc_frame_buffer.sv
// mfcc_frame_buffer: ping-pong frame buffer turning the mfcc coefficient stream into valid/ready frames; ports: mfcc_in/mfcc_valid/num_mfcc_coeffs in, out_data/out_valid/out_ready/out_last stream, frame_count/drop_count/overflow/cfg_err status
module mfcc_frame_buffer #(
  parameter int COEF_W = 32,
  parameter int MAX_COEFFS = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COEF_W-1:0] mfcc_in,
  input  logic              mfcc_valid,
  input  logic [7:0]        num_mfcc_coeffs,
  output logic [COEF_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [15:0]       frame_count,
  output logic [DROP_W-1:0] drop_count,
  output logic              overflow,
  output logic              cfg_err
);
  localparam int LW = $clog2(MAX_COEFFS + 1);
  localparam int AW = $clog2(MAX_COEFFS);
  typedef enum logic {IDLE, STREAM} state_t;
  logic [COEF_W-1:0] mem [2][MAX_COEFFS];
  logic [LW-1:0] len [2];
  logic [LW-1:0] cur_n, n_in, n;
  logic [1:0] full, full_nxt;
  logic [AW-1:0] wr_cnt, rd_cnt;
  logic wr_bank, rd_bank, rd_bank_nxt, dropping;
  logic start, bad_len, drop, last_wr, wr_done, xfer, rd_done;
  state_t state, state_nxt;
  assign bad_len = num_mfcc_coeffs == 8'd0 || num_mfcc_coeffs > 8'(MAX_COEFFS);
  assign n_in = num_mfcc_coeffs == 8'd0 ? LW'(1) :
                num_mfcc_coeffs > 8'(MAX_COEFFS) ? LW'(MAX_COEFFS) : num_mfcc_coeffs[LW-1:0];
  assign start = mfcc_valid && wr_cnt == '0;
  // drop decision uses the full flag before the edge, so a bank freed this cycle still drops
  assign drop = start ? full[wr_bank] : dropping;
  assign n = start ? n_in : cur_n;
  assign last_wr = mfcc_valid && LW'(wr_cnt) == n - LW'(1);
  assign wr_done = last_wr && !drop;
  assign out_valid = state == STREAM;
  assign out_data = out_valid ? mem[rd_bank][rd_cnt] : '0;
  assign out_last = out_valid && LW'(rd_cnt) == len[rd_bank] - LW'(1);
  assign xfer = out_valid && out_ready;
  assign rd_done = xfer && out_last;
  // next state looks at post-edge full flags so a just-completed frame streams next cycle
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    rd_bank_nxt = rd_bank ^ rd_done;
    state_nxt = full_nxt[rd_bank_nxt] ? STREAM : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      dropping <= 1'b0;
      cur_n <= '0;
      len <= '{default: '0};
      frame_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nxt;
      full <= full_nxt;
      rd_bank <= rd_bank_nxt;
      if (xfer) rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
      if (rd_done) frame_count <= frame_count + 1'b1;
      if (start) begin
        cur_n <= n_in;
        dropping <= full[wr_bank];
        if (bad_len) cfg_err <= 1'b1;
        if (!full[wr_bank]) len[wr_bank] <= n_in;
        if (full[wr_bank]) overflow <= 1'b1;
        if (full[wr_bank] && !(&drop_count)) drop_count <= drop_count + 1'b1;
      end
      if (mfcc_valid) wr_cnt <= last_wr ? '0 : wr_cnt + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end
  always_ff @(posedge clk) if (!rst && mfcc_valid && !drop) mem[wr_bank][wr_cnt] <= mfcc_in;
endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// tb_mfcc_frame_buffer: scoreboard and table-driven bench for mfcc_frame_buffer
module tb_mfcc_frame_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mfcc_in = '0;
  logic mfcc_valid = 1'b0;
  logic [7:0] num_mfcc_coeffs = 8'd13;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic out_last;
  logic [15:0] frame_count;
  logic [7:0] drop_count;
  logic overflow;
  logic cfg_err;
  typedef struct {logic [31:0] d; logic l;} exp_t;
  typedef struct {logic [7:0] cfg; int n; int len; logic err;} vec_t;
  exp_t q[$];
  exp_t e;
  vec_t tab[7];
  int total = 0;
  int bad = 0;
  int beats = 0;
  logic pv = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  mfcc_frame_buffer dut (
    .clk(clk), .rst(rst), .mfcc_in(mfcc_in), .mfcc_valid(mfcc_valid),
    .num_mfcc_coeffs(num_mfcc_coeffs), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_count(frame_count),
    .drop_count(drop_count), .overflow(overflow), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  // outputs are sampled mid-cycle; inputs only change 1ns after the rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (pv) chk("hold", {out_valid, out_last, out_data}, {1'b1, pl, pd});
      if (out_valid && out_ready) begin
        beats++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0h want none", out_data);
        end else begin
          e = q.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_last", out_last, e.l);
        end
      end
    end
    pv <= !rst && out_valid && !out_ready;
    pl <= out_last;
    pd <= out_data;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(int n, logic [31:0] base, logic [7:0] cfg, int push_n, int len);
    for (int i = 0; i < n; i++) begin
      mfcc_valid = 1'b1;
      mfcc_in = base + i;
      num_mfcc_coeffs = cfg;
      if (i < push_n) q.push_back('{base + i, (i % len) == len - 1});
      tick();
    end
    mfcc_valid = 1'b0;
  endtask
  task automatic drain;
    for (int c = 0; c < 300 && q.size() != 0; c++) tick();
    chk("drain_left", q.size(), 0);
    tick();
    tick();
  endtask
  task automatic do_reset;
    rst = 1'b1;
    mfcc_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    beats = 0;
    chk("rst_outs", {out_data, out_valid, out_last, frame_count, drop_count, overflow, cfg_err}, '0);
  endtask
  initial begin
    tab[0] = '{8'd13, 13, 13, 1'b0};
    tab[1] = '{8'd4, 4, 4, 1'b0};
    tab[2] = '{8'd1, 1, 1, 1'b0};
    tab[3] = '{8'd16, 16, 16, 1'b0};
    tab[4] = '{8'd0, 1, 1, 1'b1};
    tab[5] = '{8'd17, 16, 16, 1'b1};
    tab[6] = '{8'd255, 16, 16, 1'b1};
    tick();
    do_reset();
    // single frame, latency and order
    out_ready = 1'b1;
    send(12, 32'h100, 8'd13, 12, 13);
    mfcc_valid = 1'b1;
    mfcc_in = 32'h10C;
    q.push_back('{32'h10C, 1'b1});
    chk("lat_before", out_valid, 0);
    tick();
    mfcc_valid = 1'b0;
    chk("lat_after", out_valid, 1);
    chk("lat_data", out_data, 32'h100);
    drain();
    chk("t1_frames", frame_count, 1);
    chk("t1_beats", beats, 13);
    chk("t1_ovf", overflow, 0);
    chk("t1_idle", out_valid, 0);
    // backpressure pattern 1,0,0
    do_reset();
    send(13, 32'h100, 8'd13, 13, 13);
    for (int c = 0; c < 300 && q.size() != 0; c++) begin
      out_ready = (c % 3) == 0;
      tick();
    end
    chk("t2_left", q.size(), 0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("t2_beats", beats, 13);
    chk("t2_frames", frame_count, 1);
    // third frame dropped while both banks full
    do_reset();
    send(39, 32'h100, 8'd13, 26, 13);
    chk("t3_drops", drop_count, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_frames0", frame_count, 0);
    out_ready = 1'b1;
    drain();
    chk("t3_beats", beats, 26);
    chk("t3_frames", frame_count, 2);
    // length change between frames
    do_reset();
    out_ready = 1'b1;
    send(13, 32'h200, 8'd13, 13, 13);
    send(4, 32'h400, 8'd4, 4, 4);
    drain();
    chk("t4_beats", beats, 17);
    chk("t4_frames", frame_count, 2);
    // oversize length clamps, surplus starts a new unfinished frame
    do_reset();
    out_ready = 1'b1;
    send(20, 32'h300, 8'd20, 16, 16);
    drain();
    chk("t5_err", cfg_err, 1);
    chk("t5_beats", beats, 16);
    chk("t5_frames", frame_count, 1);
    chk("t5_idle", out_valid, 0);
    // reset discards a partial frame
    do_reset();
    send(5, 32'hDEAD0, 8'd13, 0, 13);
    do_reset();
    out_ready = 1'b1;
    send(13, 32'h500, 8'd13, 13, 13);
    drain();
    chk("t6_beats", beats, 13);
    chk("t6_frames", frame_count, 1);
    // length table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      out_ready = 1'b1;
      send(tab[i].n, 32'h1000 * (i + 1), tab[i].cfg, tab[i].n, tab[i].len);
      drain();
      chk("tab_frames", frame_count, 1);
      chk("tab_err", cfg_err, tab[i].err);
      chk("tab_beats", beats, tab[i].n);
      chk("tab_idle", out_valid, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mfcc_frame_buffer.md
Name: mfcc_frame_buffer

Overview:
- Consumer end of the mfcc_accelerator output stream (mfcc_out/mfcc_valid).
- Groups the un-throttled coefficient stream into per-frame feature vectors in a two-bank ping-pong register buffer.
- Replays each vector to the downstream classifier over a valid/ready stream with end-of-frame marking.
- The accelerator has no backpressure, so frames that cannot be stored are dropped whole and counted.

Parameters:
- COEF_W, 32, coefficient width (matches mfcc_out).
- MAX_COEFFS, 16, maximum coefficients per frame, i.e. the depth of each bank.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- mfcc_in  in  COEF_W  coefficient from accelerator.
- mfcc_valid  in  1  mfcc_in valid this cycle; no ready, always accepted or dropped.
- num_mfcc_coeffs  in  8  coefficients per frame; sampled at each frame's first coefficient.
- out_data  out  COEF_W  coefficient to downstream.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  out_data is the final coefficient of its frame.
- frame_count  out  16  frames fully delivered downstream; wraps.
- drop_count  out  DROP_W  frames dropped; saturates at all-ones.
- overflow  out  1  sticky, set on any drop.
- cfg_err  out  1  sticky, set on an illegal num_mfcc_coeffs.

Behaviour:
- Reset (clk edge with rst=1): both banks empty; wr_bank=rd_bank=0; wr_cnt=rd_cnt=0; drop mode off.
  - All outputs 0 (out_data 0, out_valid 0, out_last 0, counters 0, flags 0).
  - A partial frame in progress is discarded. rst overrides all other activity that cycle.
- Length latch (mfcc_valid with wr_cnt==0): N = num_mfcc_coeffs.
  - N==0: use N=1 and set cfg_err.
  - N>MAX_COEFFS: use N=MAX_COEFFS and set cfg_err.
  - Surplus upstream coefficients simply start the next frame.
- Write side:
  - Frame start with full[wr_bank]==0: store N in len[wr_bank], write mfcc_in to mem[wr_bank][0], then increment wr_cnt on each later mfcc_valid.
  - On the coefficient where wr_cnt==N-1: set full[wr_bank], toggle wr_bank, clear wr_cnt.
- Drop:
  - Frame start with full[wr_bank]==1 (value before the edge): enter drop mode and count N coefficients without writing.
  - On the first coefficient: drop_count+1 (saturating) and set overflow.
  - wr_bank is unchanged.
  - A bank freed by a read on the same edge still counts as full, so that frame is dropped.
- Read side, 2-state FSM:
  - IDLE -> STREAM when full[rd_bank]==1. In STREAM, out_valid=1, out_data=mem[rd_bank][rd_cnt], out_last=(rd_cnt==len[rd_bank]-1).
  - Transfer = out_valid&&out_ready, which increments rd_cnt.
  - Transfer with out_last: clear full[rd_bank], toggle rd_bank, clear rd_cnt, frame_count+1. Go to IDLE, or stay in STREAM with no bubble if the other bank is already full.
- Latency: last coefficient of a frame presented in cycle k (bank empty, reader idle) gives out_valid=1 in cycle k+1.
  - Steady state is one coefficient per cycle with out_ready held high.
- Stability: while out_valid && !out_ready, out_data, out_last and out_valid hold unchanged. out_valid never drops without a transfer except on rst.
- Simultaneous events:
  - A write completing into one bank and a read draining the other on the same edge are both honoured.
  - The write and read sides never touch the same bank in the same cycle, because the full flag gates them.
- Order: frames are delivered strictly in arrival order. Dropped frames leave no trace in the output stream.

Test Plan:
1. num_mfcc_coeffs=13, 13 consecutive coefficients 0x100..0x10C, out_ready=1 -> out_valid rises the cycle after 0x10C; 13 beats 0x100..0x10C; out_last only on 0x10C; frame_count=1; overflow=0.
2. Same frame with out_ready pattern 1,0,0,1,... -> each beat held stable while ready=0; sequence and out_last unchanged; 13 transfers total.
3. out_ready=0, three 13-coefficient frames A, B, C -> C dropped, drop_count=1, overflow=1. Then out_ready=1 -> 26 beats, A then B, out_last on beats 13 and 26; frame_count=2.
4. Frame of 13 then num_mfcc_coeffs=4, frame of 4 -> out_last on the 13th and 17th beats; frame_count=2.
5. num_mfcc_coeffs=20, 20 coefficients -> cfg_err=1; frame of the first 16 coefficients (out_last on the 16th); the remaining 4 start a second frame still filling (no output yet).
6. rst for 1 cycle after 5 of 13 coefficients -> all outputs 0. A subsequent full 13-coefficient frame is delivered intact, and none of the 5 pre-reset values appear.
